// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcode/funct values, FSM states and mux/ALU encodings (CTRL_PERF_EN enables perf counters in the top)
package multicycle_ctrl_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;
   localparam logic [1:0] SRCB_RT = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH2 = 2'd3;
   localparam logic [1:0] PCSRC_ALU = 2'd0, PCSRC_ALUOUT = 2'd1, PCSRC_JUMP = 2'd2;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_WR,
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
   } state_t;
   typedef enum logic [1:0] {AOP_NONE, AOP_ADD, AOP_SUB, AOP_FUNCT} alu_op_t;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: IR fields, status and memory handshake in, datapath controls out
interface multicycle_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_write;
   logic       i_or_d;
   logic       ir_write;
   logic       pc_write;
   logic       pc_write_cond;
   logic [1:0] pc_source;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_ctl;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       halted;
   modport master (
      input  opcode, funct, zero, mem_ready,
      output mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
             alu_src_a, alu_src_b, alu_ctl, reg_dst, mem_to_reg, reg_write, halted
   );
   modport slave (
      output opcode, funct, zero, mem_ready,
      input  mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
             alu_src_a, alu_src_b, alu_ctl, reg_dst, mem_to_reg, reg_write, halted
   );
endinterface

// File: rtl/multicycle_ctrl_alu_ctrl.sv
// alu_ctrl: maps the state's ALU operation class and funct field to an alu_ctl code
module alu_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  alu_op_t    i_op,
   input  logic [5:0] i_funct,
   output logic [3:0] o_alu_ctl
);
   logic [3:0] w_funct_ctl;
   // R-type funct decode; unrecognised funct quietly falls back to ADD
   always_comb begin
      w_funct_ctl = ALU_ADD;
      case (i_funct)
         FN_SUB:  w_funct_ctl = ALU_SUB;
         FN_AND:  w_funct_ctl = ALU_AND;
         FN_OR:   w_funct_ctl = ALU_OR;
         FN_SLT:  w_funct_ctl = ALU_SLT;
         default: w_funct_ctl = ALU_ADD;
      endcase
   end
   assign o_alu_ctl = (i_op == AOP_FUNCT) ? w_funct_ctl :
                      (i_op == AOP_SUB)   ? ALU_SUB     :
                      (i_op == AOP_ADD)   ? ALU_ADD     : ALU_AND;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer; CTRL_PERF_EN adds cycle and instruction counters
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter bit RESET_PC_WR = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master ctrl
`ifdef CTRL_PERF_EN
   ,
   output logic [31:0]       o_cycle_cnt,
   output logic [31:0]       o_instr_cnt
`endif
);
   state_t     r_state;
   state_t     w_next;
   logic       r_first;
   alu_op_t    w_alu_op;
   logic [3:0] w_alu_ctl;
   // next state: memory states wait on mem_ready, TRAP is left only by reset
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = ctrl.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: w_next = (ctrl.opcode == OP_RTYPE) ? S_EXEC_R :
                            (ctrl.opcode == OP_ADDI)  ? S_EXEC_I :
                            (ctrl.opcode == OP_LW || ctrl.opcode == OP_SW) ? S_ADDR :
                            (ctrl.opcode == OP_BEQ)   ? S_BRANCH :
                            (ctrl.opcode == OP_J)     ? S_JUMP   : S_TRAP;
         S_EXEC_R: w_next = S_WB_R;
         S_EXEC_I: w_next = S_WB_I;
         S_ADDR:   w_next = (ctrl.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: w_next = ctrl.mem_ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR: w_next = ctrl.mem_ready ? S_FETCH : S_MEM_WR;
         S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
         default:  w_next = S_TRAP;
      endcase
   end
   // state register; r_first flags the first cycle after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_first <= 1'b1;
      end else begin
         r_state <= w_next;
         r_first <= 1'b0;
      end
   end
   // control decode from state; everything is held low while reset is asserted so mem_req drops at once
   always_comb begin
      ctrl.mem_req       = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.i_or_d        = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.pc_source     = PCSRC_ALU;
      ctrl.alu_src_a     = 1'b0;
      ctrl.alu_src_b     = SRCB_RT;
      ctrl.reg_dst       = 1'b0;
      ctrl.mem_to_reg    = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.halted        = 1'b0;
      w_alu_op           = AOP_NONE;
      if (rst_n) begin
         case (r_state)
            S_FETCH: begin
               ctrl.mem_req   = 1'b1;
               ctrl.alu_src_b = SRCB_FOUR;
               w_alu_op       = AOP_ADD;
               ctrl.ir_write  = ctrl.mem_ready;
               ctrl.pc_write  = ctrl.mem_ready | (RESET_PC_WR & r_first);
            end
            S_DECODE: begin
               ctrl.alu_src_b = SRCB_IMM_SH2;
               w_alu_op       = AOP_ADD;
            end
            S_EXEC_R: begin
               ctrl.alu_src_a = 1'b1;
               w_alu_op       = AOP_FUNCT;
            end
            S_EXEC_I, S_ADDR: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_IMM;
               w_alu_op       = AOP_ADD;
            end
            S_WB_R: begin
               ctrl.reg_dst   = 1'b1;
               ctrl.reg_write = 1'b1;
            end
            S_WB_I: ctrl.reg_write = 1'b1;
            S_MEM_RD, S_MEM_WR: begin
               ctrl.mem_req   = 1'b1;
               ctrl.i_or_d    = 1'b1;
               ctrl.mem_write = (r_state == S_MEM_WR);
            end
            S_WB_MEM: begin
               ctrl.mem_to_reg = 1'b1;
               ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
               ctrl.alu_src_a     = 1'b1;
               w_alu_op           = AOP_SUB;
               ctrl.pc_write_cond = 1'b1;
               ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = PCSRC_JUMP;
            end
            S_TRAP:  ctrl.halted = 1'b1;
            default: ctrl.halted = 1'b0;
         endcase
      end
   end
   alu_ctrl u_alu_ctrl (
      .i_op      (w_alu_op),
      .i_funct   (ctrl.funct),
      .o_alu_ctl (w_alu_ctl)
   );
   assign ctrl.alu_ctl = w_alu_ctl;
`ifdef CTRL_PERF_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instr_cnt;
   // cycles exclude TRAP; an instruction retires on every return to FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= 32'd0;
         r_instr_cnt <= 32'd0;
      end else begin
         if (r_state != S_TRAP) r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (r_state != S_FETCH && w_next == S_FETCH) r_instr_cnt <= r_instr_cnt + 32'd1;
      end
   end
   assign o_cycle_cnt = r_cycle_cnt;
   assign o_instr_cnt = r_instr_cnt;
`endif
endmodule
